// File: rtl/approx_error_monitor.sv
// approx_error_monitor: exhaustive stimulus generator and error checker for
// combinational approximate |a-b| circuits. Drives every input vector once,
// captures the circuit response one cycle later and accumulates error stats.
module approx_error_monitor #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 3,
  parameter int unsigned ET    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [IN_W-1:0]         dut_in,
  input  logic [OUT_W-1:0]        dut_out,
  output logic                    busy,
  output logic                    done,
  output logic [OUT_W-1:0]        max_err,
  output logic [IN_W:0]           err_count,
  output logic [OUT_W+IN_W-1:0]   err_sum,
  output logic                    pass,
  output logic                    fail_valid,
  output logic [IN_W-1:0]         fail_vec
);

  localparam int unsigned HALF_W = IN_W / 2;
  localparam int unsigned CNT_W  = IN_W + 1;
  localparam int unsigned SUM_W  = OUT_W + IN_W;
  localparam logic [IN_W-1:0] LAST_VEC = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   busy_d;
  logic   done_d;
  logic   start_ok;

  // Stage-1 capture of the stimulus and the circuit's response
  logic              s1_valid;
  logic [IN_W-1:0]   s1_vec;
  logic [OUT_W-1:0]  s1_out;

  // Stage-2 combinational error evaluation
  logic [HALF_W-1:0] op_a;
  logic [HALF_W-1:0] op_b;
  logic [HALF_W-1:0] exact_half;
  logic [OUT_W-1:0]  exact;
  logic [OUT_W-1:0]  err;
  logic [OUT_W-1:0]  max_next;
  logic              over_et;

  assign start_ok = (state_q == IDLE) && start;

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = SWEEP;
      SWEEP:   if (dut_in == LAST_VEC) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SWEEP) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // State register and control outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Stimulus counter; parks on the last vector so dut_in stays quiet when idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dut_in <= '0;
    end else if (start_ok) begin
      dut_in <= '0;
    end else if ((state_q == SWEEP) && (dut_in != LAST_VEC)) begin
      dut_in <= dut_in + IN_W'(1);
    end
  end

  // Stage 1: sample the vector together with the circuit output it produced
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
      s1_out   <= '0;
    end else begin
      s1_valid <= (state_q == SWEEP);
      if (state_q == SWEEP) begin
        s1_vec <= dut_in;
        s1_out <= dut_out;
      end
    end
  end

  // Exact reference and absolute error of the captured response
  always_comb begin
    op_a       = s1_vec[HALF_W-1:0];
    op_b       = s1_vec[IN_W-1:HALF_W];
    exact_half = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
    exact      = OUT_W'(exact_half);
    err        = (exact >= s1_out) ? (exact - s1_out) : (s1_out - exact);
    over_et    = s1_valid && (32'(err) > ET);
    max_next   = (s1_valid && (err > max_err)) ? err : max_err;
  end

  // Stage 2: statistics accumulation, first-failure latch and verdict
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_err    <= '0;
      err_count  <= '0;
      err_sum    <= '0;
      pass       <= 1'b0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (start_ok) begin
      max_err    <= '0;
      err_count  <= '0;
      err_sum    <= '0;
      pass       <= 1'b0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      if (s1_valid) begin
        max_err <= max_next;
        err_sum <= err_sum + SUM_W'(err);
        if (err != '0) err_count <= err_count + CNT_W'(1);
        if (over_et && !fail_valid) begin
          fail_valid <= 1'b1;
          fail_vec   <= s1_vec;
        end
      end
      // Verdict includes the final vector, which is accounted on this same edge
      if (state_q == DRAIN) pass <= (32'(max_next) <= ET);
    end
  end

endmodule

// File: doc/approx_error_monitor.md
# approx_error_monitor

Sequential exhaustive-evaluation harness for approximate absolute-difference circuits. It generates every input vector, drives the combinational approximate circuit under test, and captures that circuit's outputs. It then compares each output against the exact |a−b| value and accumulates worst-case error, error count, error sum and first failing vector. It sits both upstream (stimulus) and downstream (checking) of the approximate circuit in the evaluation wrapper.

## Interface
- IN_W, default 4: total DUT input bits (even); operand a = vector[IN_W/2-1:0], b = vector[IN_W-1:IN_W/2].
- OUT_W, default 3: DUT output bits (≥ IN_W/2); exact value zero-extended to OUT_W.
- ET, default 1: error threshold; a vector fails when error > ET.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin a sweep; accepted only in IDLE.
- dut_in  out  IN_W  stimulus vector to the approximate circuit (registered).
- dut_out  in  OUT_W  approximate circuit output, combinational from dut_in.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  one-cycle pulse when results are final.
- max_err  out  OUT_W  maximum |exact − approx| seen.
- err_count  out  IN_W+1  number of vectors with nonzero error.
- err_sum  out  OUT_W+IN_W  sum of |exact − approx| over all vectors.
- pass  out  1  max_err ≤ ET; valid from done until next start.
- fail_valid  out  1  at least one vector exceeded ET.
- fail_vec  out  IN_W  first (lowest-index) vector with error > ET.

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE: start=1 → SWEEP. In the same edge, clear max_err, err_count, err_sum, pass, fail_valid and fail_vec; set vec=0.
- SWEEP: dut_in = vec. Each edge: stage-1 register captures {vec, dut_out} with s1_valid=1; vec increments. When vec = 2^IN_W−1 is captured → DRAIN.
- DRAIN: one cycle; stage 2 processes the last capture; s1_valid cleared → DONE.
- DONE: one cycle; done=1; pass = (max_err ≤ ET) registered here → IDLE.
- Stage 2, when s1_valid=1:
  - exact = |a−b| computed at IN_W/2 bits, zero-extended.
  - err = |exact − approx| at OUT_W bits, no overflow possible.
  - max_err = max(max_err, err).
  - err_count increments if err≠0.
  - err_sum adds err; widths are sized so they never wrap.
  - If err > ET and fail_valid=0: fail_vec = s1_vec, fail_valid=1. Later failures do not overwrite.
- start in SWEEP, DRAIN or DONE is ignored (no restart, no clear).
- Results and fail info hold after done until the next accepted start.
- dut_in holds its last value outside SWEEP; the value is don't-care, but it must not toggle.

## Timing
- Reset (rst_n=0 at an edge): state IDLE. busy, done, pass, fail_valid = 0. max_err, err_count, err_sum, fail_vec, dut_in, vec = 0. s1_valid = 0.
- Reset mid-sweep aborts immediately with the same values. No done is produced.
- Start accepted at edge 0:
  - busy=1 and dut_in=k during cycle k+1, for k = 0..2^IN_W−1.
  - Stats for vector k are updated at the end of cycle k+2.
  - DRAIN occupies cycle 2^IN_W+1.
  - done=1 and busy=0 in cycle 2^IN_W+2 (cycle 18 for IN_W=4).
- Throughput: one vector per clock; total latency from start to done is 2^IN_W+2 cycles.
- A start asserted in the done cycle is ignored; the earliest restart is the following cycle.

## Test plan
- Exact DUT model (dut_out = |a−b|), start at cycle 0 → busy cycles 1–17, done at cycle 18; max_err=0, err_count=0, err_sum=0, pass=1, fail_valid=0.
- Constant-zero DUT (dut_out=0), ET=1 → max_err=3, err_count=12, err_sum=20, pass=0, fail_valid=1, fail_vec=4'h2 (a=2, b=0).
- LSB-flip DUT (dut_out = exact ^ 1) → max_err=1, err_count=16, err_sum=16, pass=1, fail_valid=0.
- Exact DUT with start pulsed again at cycles 5 and 18 → both ignored; single done at cycle 18; results unchanged.
- Reset asserted at cycle 8 of a sweep → next cycle all outputs 0, busy=0, no done. A new start then runs a clean, full sweep with correct results.
- Back-to-back runs, zero DUT then exact DUT, restarted at cycle 19 → second run reports max_err=0, err_count=0, pass=1; no stale fail_vec.
